// File: rtl/hog_pkg.sv
// hog_pkg: shared HOG constants and a constant-evaluable clog2 helper.
// Contents: BINS_DEFAULT (default orientation bin count), BIN_IDX_W (bin_index width), clog2().
package hog_pkg;
    localparam int BINS_DEFAULT = 9;
    localparam int BIN_IDX_W = 4;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/hist_bin_update.sv
// hist_bin_update: combinational add of one magnitude into one bin of a packed histogram.
// Ports: i_bins (packed bins, bin 0 in LSBs), i_magnitude, i_bin_index -> o_bins.
// Macro CELL_HIST_SATURATE_EN: clamp each add at 2^BIN_WIDTH-1; otherwise wrap modulo 2^BIN_WIDTH.
// An out-of-range bin index matches no bin, so the vector passes through unchanged.
module hist_bin_update
    import hog_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BINS = BINS_DEFAULT,
    parameter int BIN_WIDTH = 14
)(
    input  logic [BINS*BIN_WIDTH-1:0] i_bins,
    input  logic [DATA_WIDTH-1:0]     i_magnitude,
    input  logic [BIN_IDX_W-1:0]      i_bin_index,
    output logic [BINS*BIN_WIDTH-1:0] o_bins
);
    genvar b;
    for (b = 0; b < BINS; b++) begin : g_bin
        logic [BIN_WIDTH-1:0] w_old;
        logic [BIN_WIDTH-1:0] w_new;
        assign w_old = i_bins[b*BIN_WIDTH +: BIN_WIDTH];
`ifdef CELL_HIST_SATURATE_EN
        localparam int SW = (BIN_WIDTH > DATA_WIDTH ? BIN_WIDTH : DATA_WIDTH) + 1;
        logic [SW-1:0] w_sum;
        assign w_sum = SW'(w_old) + SW'(i_magnitude);
        assign w_new = (w_sum > SW'({BIN_WIDTH{1'b1}})) ? '1 : w_sum[BIN_WIDTH-1:0];
`else
        assign w_new = w_old + BIN_WIDTH'(i_magnitude);
`endif
        assign o_bins[b*BIN_WIDTH +: BIN_WIDTH] = (i_bin_index == BIN_IDX_W'(b)) ? w_new : w_old;
    end
endmodule

// File: rtl/cell_histogram_acc.sv
// cell_histogram_acc: accumulates per-cell orientation histograms from a raster pixel stream.
// Ports: clk, rst (async, active-high); in_valid/in_ready/magnitude/bin_index pixel input;
//        out_valid/out_ready handshake with full_histogram, cell_x, cell_y, frame_done.
// Macro CELL_HIST_SATURATE_EN selects saturating bin adds (see hist_bin_update).
// One accumulator per cell column is enough because cells of a cell row are completed
// before the next cell row starts using the same accumulator.
module cell_histogram_acc
    import hog_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMAGE_WIDTH = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int CELL_SIZE = 8,
    parameter int BINS = BINS_DEFAULT,
    parameter int BIN_WIDTH = DATA_WIDTH + 2 * clog2(CELL_SIZE)
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     magnitude,
    input  logic [BIN_IDX_W-1:0]      bin_index,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BINS*BIN_WIDTH-1:0] full_histogram,
    output logic [15:0]               cell_x,
    output logic [15:0]               cell_y,
    output logic                      frame_done
);
    localparam int CW = IMAGE_WIDTH / CELL_SIZE;
    localparam int LW = clog2(CELL_SIZE);
    localparam int XW = (CW > 1) ? clog2(CW) : 1;
    localparam int HW = BINS * BIN_WIDTH;

    logic [15:0]   r_col;
    logic [15:0]   r_row;
    logic [HW-1:0] r_acc [CW];
    logic [HW-1:0] r_hist;
    logic          r_out_valid;
    logic [15:0]   r_cx;
    logic [15:0]   r_cy;
    logic          r_fd;

    logic [XW-1:0] w_cx;
    logic [HW-1:0] w_upd;
    logic          w_fire;
    logic          w_row_end;
    logic          w_cell_end;
    logic          w_frame_end;

    assign in_ready       = !r_out_valid || out_ready;
    assign w_fire         = in_valid && in_ready;
    assign w_cx           = XW'(r_col >> LW);
    assign w_row_end      = r_col == 16'(IMAGE_WIDTH - 1);
    // Bottom-right pixel of a cell: both low (cell-local) coordinate bits all ones.
    assign w_cell_end     = (r_col[LW-1:0] == {LW{1'b1}}) && (r_row[LW-1:0] == {LW{1'b1}});
    assign w_frame_end    = w_row_end && (r_row == 16'(IMAGE_HEIGHT - 1));
    assign out_valid      = r_out_valid;
    assign full_histogram = r_hist;
    assign cell_x         = r_cx;
    assign cell_y         = r_cy;
    assign frame_done     = r_fd;

    hist_bin_update #(
        .DATA_WIDTH(DATA_WIDTH),
        .BINS      (BINS),
        .BIN_WIDTH (BIN_WIDTH)
    ) u_upd (
        .i_bins     (r_acc[w_cx]),
        .i_magnitude(magnitude),
        .i_bin_index(bin_index),
        .o_bins     (w_upd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            for (int i = 0; i < CW; i++) r_acc[i] <= '0;
            r_hist      <= '0;
            r_out_valid <= 1'b0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_fd        <= 1'b0;
        end else begin
            if (w_fire) begin
                // The completing pixel hands its sum to the output and frees the accumulator.
                r_acc[w_cx] <= w_cell_end ? '0 : w_upd;
                r_col       <= w_row_end ? '0 : r_col + 16'd1;
                if (w_row_end) r_row <= (r_row == 16'(IMAGE_HEIGHT - 1)) ? '0 : r_row + 16'd1;
            end
            if (w_fire && w_cell_end) begin
                r_out_valid <= 1'b1;
                r_hist      <= w_upd;
                r_cx        <= 16'(w_cx);
                r_cy        <= r_row >> LW;
                r_fd        <= w_frame_end;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cell_histogram_acc.sv
// tb_cell_histogram_acc: scoreboard bench for cell_histogram_acc on a 16x16 image with 4x4 cells.
module tb_cell_histogram_acc;
    localparam int IW = 16, IH = 16, CS = 4, BW = 12, NB = 9, HW = NB * BW, NCX = IW / CS;

    logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
    logic in_ready, out_valid, frame_done;
    logic [7:0] magnitude = 0;
    logic [3:0] bin_index = 0;
    logic [HW-1:0] full_histogram;
    logic [15:0] cell_x, cell_y;

    logic in_valid8 = 0, out_ready8 = 1;
    logic in_ready8, out_valid8, fd8;
    logic [7:0] magnitude8 = 8'd255;
    logic [3:0] bin8 = 4'd0;
    logic [NB*8-1:0] hist8;
    logic [15:0] cx8, cy8;

    always #5 clk = ~clk;

    cell_histogram_acc #(.DATA_WIDTH(8), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .CELL_SIZE(CS),
                         .BINS(NB), .BIN_WIDTH(BW)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .magnitude(magnitude),
        .bin_index(bin_index), .out_valid(out_valid), .out_ready(out_ready),
        .full_histogram(full_histogram), .cell_x(cell_x), .cell_y(cell_y), .frame_done(frame_done));

    cell_histogram_acc #(.DATA_WIDTH(8), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .CELL_SIZE(CS),
                         .BINS(NB), .BIN_WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .magnitude(magnitude8),
        .bin_index(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .full_histogram(hist8), .cell_x(cx8), .cell_y(cy8), .frame_done(fd8));

    typedef struct {
        logic [HW-1:0] h;
        int cx;
        int cy;
        logic fd;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0, errors = 0;
    int acc[NCX][NB];
    int model_p = 0;
    int stall_left = 0;
    bit rand_ready = 0, gaps = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int bin_add(input int a, input int m, input int w);
`ifdef CELL_HIST_SATURATE_EN
        return (a + m > (1 << w) - 1) ? (1 << w) - 1 : a + m;
`else
        return (a + m) % (1 << w);
`endif
    endfunction

    task automatic model_reset();
        model_p = 0;
        for (int x = 0; x < NCX; x++)
            for (int b = 0; b < NB; b++) acc[x][b] = 0;
        exp_q.delete();
    endtask

    // Reference: pixel p of the frame lands in cell (col/CS,row/CS); the cell is reported when
    // its bottom-right pixel arrives.
    task automatic model_px(input int mag, input int bin);
        int p, col, row, cx;
        exp_t e;
        p = model_p % (IW * IH);
        col = p % IW;
        row = p / IW;
        cx = col / CS;
        if (bin < NB) acc[cx][bin] = bin_add(acc[cx][bin], mag, BW);
        if (col % CS == CS - 1 && row % CS == CS - 1) begin
            e.h = '0;
            for (int b = 0; b < NB; b++) e.h[b*BW +: BW] = BW'(acc[cx][b]);
            e.cx = cx;
            e.cy = row / CS;
            e.fd = (p == IW * IH - 1);
            exp_q.push_back(e);
            for (int b = 0; b < NB; b++) acc[cx][b] = 0;
        end
        model_p++;
    endtask

    // mode 0: magnitude 1 into bin 2; mode 1: random; mode 2: random with cell (0,0) in bins 9..15.
    task automatic feed(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            int mag, bin, p, waited;
            bit done;
            p = model_p % (IW * IH);
            waited = 0;
            done = 0;
            mag = (mode == 0) ? 1 : $urandom_range(0, 255);
            if (mode == 0) bin = 2;
            else if (mode == 2 && p / IW < CS && p % IW < CS) bin = $urandom_range(9, 15);
            else bin = $urandom_range(0, 10);
            while (!done) begin
                @(negedge clk);
                in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                magnitude = mag[7:0];
                bin_index = bin[3:0];
                #4;
                if (in_valid && in_ready) begin
                    model_px(mag, bin);
                    done = 1;
                end else if (++waited > 1000) begin
                    checks++;
                    errors++;
                    $display("FAIL in_ready_timeout: got in_ready=%0b expected 1 within 1000 cycles", in_ready);
                    done = 1;
                end
                @(posedge clk);
            end
        end
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: chooses out_ready each cycle and scores every accepted output.
    logic [HW-1:0] held_h;
    logic [15:0] held_x, held_y;
    bit stalling = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && stall_left > 0) begin
                if (!stalling) begin
                    held_h = full_histogram;
                    held_x = cell_x;
                    held_y = cell_y;
                    stalling = 1;
                end
                out_ready = 0;
                stall_left--;
                #1;
                check("stall_in_ready", in_ready, 0);
                check("stall_hold_hist", full_histogram, held_h);
                check("stall_hold_xy", {cell_x, cell_y}, {held_x, held_y});
            end else begin
                stalling = 0;
                out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                #1;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got cell (%0d,%0d) expected none", cell_x, cell_y);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("hist", full_histogram, e.h);
                        check("cell_xy", {cell_x, cell_y}, {16'(e.cx), 16'(e.cy)});
                        check("frame_done", frame_done, e.fd);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp8;
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_hist", full_histogram, 0);
        check("rst_xy_fd", {cell_x, cell_y, frame_done}, 0);
        @(negedge clk);
        rst = 0;

        feed(IW * IH, 0);
        drain();

        stall_left = 10;
        feed(IW * IH, 0);
        drain();
        check("stall_consumed", stall_left, 0);

        feed(IW * IH, 2);
        drain();

        // Reset while a finished cell is still waiting for the consumer.
        stall_left = 1000;
        feed(52, 1);
        @(negedge clk);
        #2;
        check("pending_before_rst", out_valid, 1);
        rst = 1;
        #1;
        check("rst_drops_out_valid", out_valid, 0);
        stall_left = 0;
        model_reset();
        @(negedge clk);
        rst = 0;

        feed(37, 1);
        @(negedge clk);
        rst = 1;
        #1;
        check("rst37_out_valid", out_valid, 0);
        check("rst37_in_ready", in_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 0;

        rand_ready = 1;
        gaps = 1;
        feed(IW * IH, 1);
        feed(IW * IH, 1);
        drain();
        rand_ready = 0;
        gaps = 0;

        // Narrow accumulator: 16 pixels of 255 in bin 0 of cell (0,0).
        exp8 = 0;
        for (int i = 0; i < CS * CS; i++) exp8 = bin_add(exp8, 255, 8);
        for (int i = 0; i < IW * (CS - 1) + CS; i++) begin
            @(negedge clk);
            in_valid8 = 1;
        end
        @(negedge clk);
        in_valid8 = 0;
        #1;
        check("bw8_out_valid", out_valid8, 1);
        check("bw8_bin0", hist8[7:0], exp8[7:0]);
        check("bw8_other_bins", hist8[NB*8-1:8], 0);
        check("bw8_cell_xy", {cx8, cy8, fd8}, 0);

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
